uart_rx_core: RTL and testbench

- Parametrised next-generation UART receiver: configurable data width, parity mode and stop-bit count.
- Adds mid-bit 3-sample majority voting, parity and framing error flags, and overrun detection.
- Output side is a valid/ready handshake holding one received frame.
- Sits between the board RX pin and the echo/command logic; replaces the fixed 8N1, 9600-baud receiver.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 48 ++++
 rtl/uart_rx_core.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// parity mode constants and the bit-timer computation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit minus one, rounded to the nearest integer.
    function automatic int calc_bit_tmr(input longint clk_freq, input longint baud);
        return int'((clk_freq + baud / 2) / baud) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: 2-FF synchroniser, 3-deep
// history register, majority vote and falling-edge detect.
module uart_rx_sampler (
    input  logic CLK,
    input  logic RST_N,
    input  logic UART_RX,
    output logic maj,
    output logic fall,
    output logic line_high
);

    logic [1:0] sync_reg;
    logic [2:0] hist_reg;
    logic [2:0] hist_next;
    logic [2:0] seen_reg;

    // hist_reg[0] is s0 (newest), hist_reg[2] is s2 (oldest).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = sync_reg[1];
            end else begin : g_tail
                assign hist_next[gi] = hist_reg[gi-1];
            end
        end
    endgenerate

    // seen_reg tracks which pipeline stages hold a real line sample rather than
    // the reset preset, so a preset 1 is never mistaken for an idle-high line.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_reg <= 2'b11;
            hist_reg <= 3'b111;
            seen_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[0], UART_RX};
            hist_reg <= hist_next;
            seen_reg <= {seen_reg[1:0], 1'b1};
        end
    end

    assign maj       = (hist_reg[2] & hist_reg[1]) | (hist_reg[2] & hist_reg[0]) |
                       (hist_reg[1] & hist_reg[0]);
    assign fall      = hist_reg[1] & ~hist_reg[0];
    assign line_high = hist_reg[0] & seen_reg[2];

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with majority sampling, parity/framing/overrun
// flags and a valid/ready output. Optional: UART_RX_BREAK_DETECT_EN adds rx_break.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 rx_break
`endif
);

    localparam int BIT_TMR  = calc_bit_tmr(CLK_FREQ, BAUD);
    localparam int HALF_TMR = BIT_TMR / 2;
    localparam int TMR_W    = $clog2(BIT_TMR + 1);
    localparam int CNT_W    = 4;

    generate
        if (BIT_TMR < 7) begin : g_bad_tmr
            $error("uart_rx_core: BIT_TMR must be at least 7");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
            $error("uart_rx_core: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_core: STOP_BITS must be 1..2");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
            $error("uart_rx_core: PARITY must be 0..2");
        end
    endgenerate

    logic maj;
    logic fall;
    logic line_high;

    uart_rx_sampler u_sampler (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .UART_RX   (UART_RX),
        .maj       (maj),
        .fall      (fall),
        .line_high (line_high)
    );

    rx_state_t             state_reg,   state_next;
    logic [TMR_W-1:0]      timer_reg,   timer_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]  shift_reg,   shift_next;
    logic                  perr_reg,    perr_next;
    logic                  ferr_reg,    ferr_next;
    logic                  armed_reg,   armed_next;
    logic [DATA_BITS-1:0]  data_reg,    data_next;
    logic                  valid_reg,   valid_next;
    logic                  perr_o_reg,  perr_o_next;
    logic                  ferr_o_reg,  ferr_o_next;
    logic                  ovr_reg,     ovr_next;
    logic                  break_reg,   break_next;
    logic                  tick_bit;
    logic                  stop_ferr;
    logic                  is_break;

`ifdef UART_RX_BREAK_DETECT_EN
    logic par_bit_reg, par_bit_next;
    assign is_break = (shift_reg == '0) && !par_bit_reg && ferr_reg;
    assign rx_break = break_reg;
`else
    assign is_break = 1'b0;
`endif

    assign tick_bit  = (timer_reg == TMR_W'(BIT_TMR));
    assign stop_ferr = ferr_reg | ~maj;

    always_comb begin
        state_next   = state_reg;
        timer_next   = tick_bit ? '0 : timer_reg + TMR_W'(1);
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        armed_next   = armed_reg;
        data_next    = data_reg;
        valid_next   = valid_reg & ~rx_ready;
        perr_o_next  = perr_o_reg;
        ferr_o_next  = ferr_o_reg;
        ovr_next     = 1'b0;
        break_next   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_next = par_bit_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                if (line_high) begin
                    armed_next = 1'b1;
                end
                if (armed_reg && fall) begin
                    state_next   = ST_START;
                    bit_cnt_next = '0;
                    perr_next    = 1'b0;
                    ferr_next    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_next = 1'b0;
`endif
                end
            end
            ST_START: begin
                // Half-bit sample re-centres the timer on mid-bit for the rest of the frame.
                if (timer_reg == TMR_W'(HALF_TMR)) begin
                    timer_next   = '0;
                    bit_cnt_next = '0;
                    state_next   = maj ? ST_IDLE : ST_DATA;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            ST_DATA: begin
                if (tick_bit) begin
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_bit) begin
                    perr_next  = ((^shift_reg) ^ maj) != (PARITY == PAR_ODD);
                    state_next = ST_STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_next = maj;
`endif
                end
            end
            ST_STOP: begin
                if (tick_bit) begin
                    ferr_next = stop_ferr;
                    if (bit_cnt_reg == CNT_W'(STOP_BITS - 1)) begin
                        state_next = ST_DONE;
                        // A low stop bit may be a break; insist on idle-high before re-arming.
                        if (stop_ferr) begin
                            armed_next = 1'b0;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                timer_next = '0;
                if (is_break) begin
                    break_next = 1'b1;
                end else if (!valid_reg || rx_ready) begin
                    data_next   = shift_reg;
                    perr_o_next = perr_reg;
                    ferr_o_next = ferr_reg;
                    valid_next  = 1'b1;
                end else begin
                    ovr_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            armed_reg   <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            perr_o_reg  <= 1'b0;
            ferr_o_reg  <= 1'b0;
            ovr_reg     <= 1'b0;
            break_reg   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            armed_reg   <= armed_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            perr_o_reg  <= perr_o_next;
            ferr_o_reg  <= ferr_o_next;
            ovr_reg     <= ovr_next;
            break_reg   <= break_next;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_reg <= par_bit_next;
`endif
        end
    end

    assign rx_data       = data_reg;
    assign rx_valid      = valid_reg;
    assign rx_parity_err = perr_o_reg;
    assign rx_frame_err  = ferr_o_reg;
    assign rx_overrun    = ovr_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance (A) and a 7E1 instance (B)
// at 1 Mbaud on a 100 MHz clock, table-driven frames plus corner sequences.
module tb_uart_rx_core;

    localparam int BIT = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_a, line_b;
    logic       rx_ready_a, rx_ready_b;
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       rx_parity_err_a, rx_parity_err_b;
    logic       rx_frame_err_a, rx_frame_err_b;
    logic       rx_overrun_a, rx_overrun_b;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       rx_break_a, rx_break_b;
`endif

    always #5 clk = ~clk;

    uart_rx_core #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .UART_RX(line_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a),
        .rx_overrun(rx_overrun_a)
`ifdef UART_RX_BREAK_DETECT_EN
        , .rx_break(rx_break_a)
`endif
    );

    uart_rx_core #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .UART_RX(line_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b),
        .rx_overrun(rx_overrun_b)
`ifdef UART_RX_BREAK_DETECT_EN
        , .rx_break(rx_break_b)
`endif
    );

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } cap_t;

    typedef struct {
        int         sel;
        logic [8:0] data;
        int         nbits;
        int         par;      // -1: no parity bit, else the bit value driven
        logic       stop;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    cap_t cap_a[$];
    cap_t cap_b[$];
    cap_t mon_a, mon_b;
    int   vcyc_a = 0, vcyc_b = 0, ovr_a = 0;
    int   errors = 0, checks = 0;

    // Transfer monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid_a && rx_ready_a) begin
            mon_a.data = 9'(rx_data_a);
            mon_a.perr = rx_parity_err_a;
            mon_a.ferr = rx_frame_err_a;
            cap_a.push_back(mon_a);
        end
        if (rx_valid_b && rx_ready_b) begin
            mon_b.data = 9'(rx_data_b);
            mon_b.perr = rx_parity_err_b;
            mon_b.ferr = rx_frame_err_b;
            cap_b.push_back(mon_b);
        end
        if (rx_valid_a)   vcyc_a++;
        if (rx_valid_b)   vcyc_b++;
        if (rx_overrun_a) ovr_a++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) line_a = v;
        else          line_b = v;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                              input int par, input logic stop, input logic final_v);
        drive(sel, 1'b0);
        wait_cyc(BIT);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, d[i]);
            wait_cyc(BIT);
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            wait_cyc(BIT);
        end
        drive(sel, stop);
        wait_cyc(BIT);
        drive(sel, final_v);
    endtask

    task automatic expect_frame(input int sel, input string nm, input logic [8:0] d,
                                input logic pe, input logic fe);
        cap_t c;
        int   n;
        n = (sel == 0) ? cap_a.size() : cap_b.size();
        chk({nm, " count"}, n, 1);
        if (n > 0) begin
            c = (sel == 0) ? cap_a.pop_front() : cap_b.pop_front();
            $display("frame %s: data=%0h perr=%0b ferr=%0b", nm, c.data, c.perr, c.ferr);
            chk({nm, " data"}, c.data, d);
            chk({nm, " perr"}, c.perr, pe);
            chk({nm, " ferr"}, c.ferr, fe);
        end
        cap_a.delete();
        cap_b.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int base_v, base_o;

        vecs[0] = '{0, 9'h0A5, 8, -1, 1'b1, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 8, -1, 1'b1, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h055, 7,  1, 1'b1, 9'h055, 1'b1, 1'b0};
        vecs[3] = '{1, 9'h055, 7,  0, 1'b1, 9'h055, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h02A, 7,  0, 1'b1, 9'h02A, 1'b1, 1'b0};
        vecs[5] = '{1, 9'h02A, 7,  1, 1'b1, 9'h02A, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h07F, 7,  1, 1'b0, 9'h07F, 1'b0, 1'b1};

        rst_n = 1'b0; line_a = 1'b1; line_b = 1'b1;
        rx_ready_a = 1'b1; rx_ready_b = 1'b1;
        wait_cyc(5);
        chk("reset valid_a", rx_valid_a, 0);
        chk("reset data_a", rx_data_a, 0);
        chk("reset errs_a", {rx_parity_err_a, rx_frame_err_a, rx_overrun_a}, 0);
        chk("reset valid_b", rx_valid_b, 0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Table-driven frames, consumer always ready.
        for (int i = 0; i < 7; i++) begin
            base_v = (vecs[i].sel == 0) ? vcyc_a : vcyc_b;
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].par,
                       vecs[i].stop, 1'b1);
            wait_cyc(50);
            expect_frame(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].exp_data,
                         vecs[i].exp_perr, vecs[i].exp_ferr);
            chk($sformatf("vec%0d valid cycles", i),
                ((vecs[i].sel == 0) ? vcyc_a : vcyc_b) - base_v, 1);
            wait_cyc(100);
        end

        // Framing error, line held low afterwards: no new frame until it idles high.
        send_frame(0, 9'h03C, 8, -1, 1'b0, 1'b0);
        wait_cyc(50);
        expect_frame(0, "ferr 3C", 9'h03C, 1'b0, 1'b1);
        wait_cyc(300);
        chk("held-low no frame", cap_a.size(), 0);
        drive(0, 1'b1);
        wait_cyc(200);
        send_frame(0, 9'h012, 8, -1, 1'b1, 1'b1);
        wait_cyc(50);
        expect_frame(0, "after ferr 12", 9'h012, 1'b0, 1'b0);
        wait_cyc(100);

        // 0xFF with a one-cycle low spike in the middle of bit 3.
        drive(0, 1'b0);
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1);
            if (i == 3) begin
                wait_cyc(50); drive(0, 1'b0);
                wait_cyc(1);  drive(0, 1'b1);
                wait_cyc(49);
            end else begin
                wait_cyc(BIT);
            end
        end
        drive(0, 1'b1);
        wait_cyc(BIT + 50);
        expect_frame(0, "spike FF", 9'h0FF, 1'b0, 1'b0);
        wait_cyc(100);

        // Overrun with consumer stalled, then drain.
        rx_ready_a = 1'b0;
        base_o = ovr_a;
        send_frame(0, 9'h011, 8, -1, 1'b1, 1'b1);
        wait_cyc(50);
        chk("ovr first valid", rx_valid_a, 1);
        chk("ovr first data", rx_data_a, 8'h11);
        chk("ovr none yet", ovr_a - base_o, 0);
        send_frame(0, 9'h022, 8, -1, 1'b1, 1'b1);
        wait_cyc(50);
        chk("ovr held data", rx_data_a, 8'h11);
        chk("ovr held valid", rx_valid_a, 1);
        chk("ovr pulse count", ovr_a - base_o, 1);
        rx_ready_a = 1'b1;
        wait_cyc(2);
        chk("ovr valid drop", rx_valid_a, 0);
        expect_frame(0, "ovr drain", 9'h011, 1'b0, 1'b0);
        wait_cyc(100);

        // 30-cycle glitch on idle line, then a held frame.
        rx_ready_a = 1'b0;
        drive(0, 1'b0);
        wait_cyc(30);
        drive(0, 1'b1);
        wait_cyc(300);
        chk("glitch no valid", rx_valid_a, 0);
        send_frame(0, 9'h05A, 8, -1, 1'b1, 1'b1);
        wait_cyc(50);
        chk("post-glitch valid", rx_valid_a, 1);
        chk("post-glitch data", rx_data_a, 8'h5A);

        // Reset during DATA of 0x77, released with the line low.
        drive(0, 1'b0);
        wait_cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1);
            wait_cyc(BIT);
        end
        drive(0, 1'b0);
        wait_cyc(50);
        rst_n = 1'b0;
        wait_cyc(3);
        chk("midreset valid", rx_valid_a, 0);
        chk("midreset data", rx_data_a, 0);
        rst_n = 1'b1;
        rx_ready_a = 1'b1;
        cap_a.delete();
        wait_cyc(500);
        chk("low after reset no frame", cap_a.size(), 0);
        chk("low after reset valid", rx_valid_a, 0);
        drive(0, 1'b1);
        wait_cyc(200);
        send_frame(0, 9'h066, 8, -1, 1'b1, 1'b1);
        wait_cyc(50);
        expect_frame(0, "after reset 66", 9'h066, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
